// File: rtl/jtag_shift_engine.sv
// Target JTAG port sequencer and owner arbiter.
// Either passes the FT2232 JTAG pins straight through (host owner) or runs an
// internal engine that shifts up to DATA_W bits of TMS/TDI with a divided TCK,
// capturing TDO on each rising TCK. The engine can also issue a timed nTRST pulse.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start / trst_req; host_sel sampled into own_host
//   LOW    | TCK low phase of the current bit, divider running
//   HIGH   | TCK high phase of the current bit, divider running
//   RST    | nTRST held low, TRST_CYC cycles
//   DONE   | one-cycle completion pulse, pins hold their last values
module jtag_shift_engine #(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 6,
    parameter int DIV_W    = 8,
    parameter int TRST_CYC = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              host_sel,
    input  logic              FT_TCK,
    input  logic              FT_TMS,
    input  logic              FT_TDI,
    input  logic              FT_nTRST_OUT,
    output logic              FT_TDO,
    input  logic              start,
    input  logic              trst_req,
    input  logic [LEN_W-1:0]  len,
    input  logic [DIV_W-1:0]  tck_div,
    input  logic [DATA_W-1:0] tms_vec,
    input  logic [DATA_W-1:0] tdi_vec,
    output logic [DATA_W-1:0] tdo_vec,
    output logic              busy,
    output logic              done,
    output logic              own_host,
    input  logic              TDO,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    output logic              nTRST
);

    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TRST_W = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DATA_W);
    localparam logic [TRST_W-1:0] TRST_LOAD = TRST_W'(TRST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RST,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [IDX_W-1:0]  last_idx;
    logic [TRST_W-1:0] trst_cnt;
    logic [DATA_W-1:0] tms_q;
    logic [DATA_W-1:0] tdi_q;
    logic              tck_r;
    logic              tms_r;
    logic              tdi_r;
    logic              ntrst_r;

    logic len_ok;
    logic accept_start;
    logic accept_trst;
    logic div_tc;
    logic trst_tc;
    logic last_bit;

    assign len_ok       = (len != '0) && (len <= LEN_MAX);
    assign accept_trst  = (state == S_IDLE) && !own_host && trst_req;
    assign accept_start = (state == S_IDLE) && !own_host && !trst_req && start && len_ok;
    assign div_tc       = (div_cnt == '0);
    assign trst_tc      = (trst_cnt == '0);
    assign last_bit     = (idx == last_idx);
    assign idx_nxt      = idx + 1'b1;

    // Pin ownership mux; TDO always goes back to the host.
    assign FT_TDO = TDO;
    assign TCK    = own_host ? FT_TCK       : tck_r;
    assign TMS    = own_host ? FT_TMS       : tms_r;
    assign TDI    = own_host ? FT_TDI       : tdi_r;
    assign nTRST  = own_host ? FT_nTRST_OUT : ntrst_r;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; trst_req wins over start in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept_trst) begin
                    next_state = S_RST;
                end else if (accept_start) begin
                    next_state = S_LOW;
                end
            end
            S_LOW: begin
                if (div_tc) begin
                    next_state = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_tc) begin
                    next_state = last_bit ? S_DONE : S_LOW;
                end
            end
            S_RST: begin
                if (trst_tc) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Engine datapath: divider/trst down-counters, bit index, pin registers, capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            own_host <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tdo_vec  <= '0;
            tck_r    <= 1'b0;
            tms_r    <= 1'b1;
            tdi_r    <= 1'b0;
            ntrst_r  <= 1'b1;
            div_q    <= '0;
            div_cnt  <= '0;
            idx      <= '0;
            last_idx <= '0;
            trst_cnt <= '0;
            tms_q    <= '0;
            tdi_q    <= '0;
        end else begin
            busy <= (next_state == S_LOW) || (next_state == S_HIGH) || (next_state == S_RST);
            done <= (next_state == S_DONE);

            // Ownership only changes while idle and not launching an operation.
            if ((state == S_IDLE) && !accept_start && !accept_trst) begin
                own_host <= host_sel;
            end

            case (state)
                S_IDLE: begin
                    if (accept_trst) begin
                        ntrst_r  <= 1'b0;
                        trst_cnt <= TRST_LOAD;
                    end else if (accept_start) begin
                        last_idx <= IDX_W'(len - 1'b1);
                        div_q    <= tck_div;
                        div_cnt  <= tck_div;
                        tms_q    <= tms_vec;
                        tdi_q    <= tdi_vec;
                        tdo_vec  <= '0;
                        idx      <= '0;
                        tck_r    <= 1'b0;
                        tms_r    <= tms_vec[0];
                        tdi_r    <= tdi_vec[0];
                    end
                end
                S_LOW: begin
                    if (div_tc) begin
                        tck_r        <= 1'b1;
                        tdo_vec[idx] <= TDO;
                        div_cnt      <= div_q;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_tc) begin
                        tck_r   <= 1'b0;
                        div_cnt <= div_q;
                        // Next bit goes out together with the falling TCK.
                        if (!last_bit) begin
                            idx   <= idx_nxt;
                            tms_r <= tms_q[idx_nxt];
                            tdi_r <= tdi_q[idx_nxt];
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_RST: begin
                    if (trst_tc) begin
                        ntrst_r <= 1'b1;
                    end else begin
                        trst_cnt <= trst_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Bench for jtag_shift_engine: directed stimulus, an operation-level model that
// predicts pin waveforms arithmetically from (start time, len, div, vectors),
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_jtag_shift_engine;

    localparam int DATA_W   = 32;
    localparam int LEN_W    = 6;
    localparam int DIV_W    = 8;
    localparam int TRST_CYC = 16;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              host_sel = 1'b1;
    logic              FT_TCK = 1'b0;
    logic              FT_TMS = 1'b1;
    logic              FT_TDI = 1'b0;
    logic              FT_nTRST_OUT = 1'b1;
    logic              FT_TDO;
    logic              start = 1'b0;
    logic              trst_req = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [DIV_W-1:0]  tck_div = '0;
    logic [DATA_W-1:0] tms_vec = '0;
    logic [DATA_W-1:0] tdi_vec = '0;
    logic [DATA_W-1:0] tdo_vec;
    logic              busy;
    logic              done;
    logic              own_host;
    logic              TDO = 1'b0;
    logic              TCK;
    logic              TMS;
    logic              TDI;
    logic              nTRST;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    jtag_shift_engine #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W), .TRST_CYC(TRST_CYC)
    ) dut (
        .CLK(CLK), .nRST(nRST), .host_sel(host_sel),
        .FT_TCK(FT_TCK), .FT_TMS(FT_TMS), .FT_TDI(FT_TDI), .FT_nTRST_OUT(FT_nTRST_OUT),
        .FT_TDO(FT_TDO), .start(start), .trst_req(trst_req), .len(len),
        .tck_div(tck_div), .tms_vec(tms_vec), .tdi_vec(tdi_vec), .tdo_vec(tdo_vec),
        .busy(busy), .done(done), .own_host(own_host), .TDO(TDO),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .nTRST(nTRST)
    );

    // Target model: TDO is TDI re-timed by a falling-edge flop.
    always @(negedge CLK) TDO <= TDI;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Waveform statistics used by the literal checks.
    int   rises = 0;
    int   high_cyc = 0;
    int   ntrst_low = 0;
    int   dones = 0;
    logic prev_tck = 1'b0;
    always @(negedge CLK) begin
        if (TCK && !prev_tck) rises++;
        if (TCK) high_cyc++;
        if (!nTRST) ntrst_low++;
        if (done) dones++;
        prev_tck = TCK;
    end

    // Operation-level model and per-cycle compare.
    int          n = 0;
    int          op_kind = 0;      // 0 none, 1 shift, 2 trst
    int          n0 = 0;
    int          m_len = 0;
    int          m_div = 0;
    logic [31:0] m_tms_v = '0;
    logic [31:0] m_tdi_v = '0;
    logic        m_own = 1'b1;
    logic        m_own_nxt = 1'b1;
    logic        m_tms = 1'b1;
    logic        m_tdi = 1'b0;
    logic [31:0] m_tdo = '0;

    initial begin
        int k, p, end_k, b;
        logic idle, accepted;
        logic e_busy, e_done, e_tck, e_tms, e_tdi, e_ntrst;
        logic [31:0] e_tdo;
        forever begin
            @(negedge CLK);
            n++;
            if (!nRST) begin
                op_kind = 0; m_own = 1'b1; m_own_nxt = 1'b1;
                m_tms = 1'b1; m_tdi = 1'b0; m_tdo = '0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_tdo_vec", tdo_vec, 0);
                chk("rst_own_host", own_host, 1);
                continue;
            end
            m_own = m_own_nxt;
            e_busy = 0; e_done = 0; e_tck = 0; e_tms = m_tms; e_tdi = m_tdi;
            e_ntrst = 1; e_tdo = m_tdo; idle = 1;
            if (op_kind != 0) begin
                k = n - n0 - 1;
                p = 2 * (m_div + 1);
                if (op_kind == 1) begin
                    end_k = m_len * p;
                    if (k < end_k) begin
                        idle = 0; e_busy = 1;
                        b = k / p;
                        e_tck = ((k % p) >= (m_div + 1));
                        e_tms = m_tms_v[b];
                        e_tdi = m_tdi_v[b];
                        e_tdo = '0;
                        for (int j = 0; j < m_len; j++)
                            if (k >= j * p + m_div + 1) e_tdo[j] = m_tdi_v[j];
                    end else if (k == end_k) begin
                        idle = 0; e_done = 1;
                        m_tms = m_tms_v[m_len-1];
                        m_tdi = m_tdi_v[m_len-1];
                        m_tdo = '0;
                        for (int j = 0; j < m_len; j++) m_tdo[j] = m_tdi_v[j];
                        e_tms = m_tms; e_tdi = m_tdi; e_tdo = m_tdo;
                    end else begin
                        op_kind = 0;
                    end
                end else begin
                    if (k < TRST_CYC) begin
                        idle = 0; e_busy = 1; e_ntrst = 0;
                    end else if (k == TRST_CYC) begin
                        idle = 0; e_done = 1;
                    end else begin
                        op_kind = 0;
                    end
                end
            end
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("tdo_vec", tdo_vec, e_tdo);
            chk("own_host", own_host, m_own);
            chk("FT_TDO", FT_TDO, TDO);
            if (m_own) begin
                chk("TCK_pass", TCK, FT_TCK);
                chk("TMS_pass", TMS, FT_TMS);
                chk("TDI_pass", TDI, FT_TDI);
                chk("nTRST_pass", nTRST, FT_nTRST_OUT);
            end else begin
                chk("TCK", TCK, e_tck);
                chk("TMS", TMS, e_tms);
                chk("TDI", TDI, e_tdi);
                chk("nTRST", nTRST, e_ntrst);
            end
            accepted = 0;
            if (idle && !m_own) begin
                if (trst_req) begin
                    op_kind = 2; n0 = n; accepted = 1;
                end else if (start && len >= 1 && len <= DATA_W) begin
                    op_kind = 1; n0 = n; accepted = 1;
                    m_len = int'(len); m_div = int'(tck_div);
                    m_tms_v = tms_vec; m_tdi_v = tdi_vec;
                end
            end
            m_own_nxt = (idle && !accepted) ? host_sel : m_own;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic zero_stats();
        rises = 0; high_cyc = 0; ntrst_low = 0; dones = 0;
    endtask

    // Launch a shift and return cycles from LOW entry to the done pulse.
    task automatic run_shift(input int l, input int d, input logic [31:0] tv,
                             input logic [31:0] dv, output int t);
        len = LEN_W'(l); tck_div = DIV_W'(d); tms_vec = tv; tdi_vec = dv;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (!done && t < 2000) begin
            tick();
            t++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        tick();
    endtask

    initial begin
        int t;
        logic [3:0] pat;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [3:0] pat;
        repeat (3) tick();
        nRST = 1'b1;
        tick();

        // Host pass-through; start is ignored while the host owns the port.
        for (int i = 0; i < 8; i++) begin
            pat = 4'(i * 5 + 3);
            {FT_TCK, FT_TMS, FT_TDI, FT_nTRST_OUT} = pat;
            if (i == 3) begin len = 6'd5; start = 1'b1; end
            #1;
            chk("pass_TCK_lit", TCK, pat[3]);
            chk("pass_nTRST_lit", nTRST, pat[0]);
            tick();
            start = 1'b0;
        end
        chk("host_no_busy", busy, 0);
        FT_TCK = 1'b0; FT_TMS = 1'b1; FT_TDI = 1'b0; FT_nTRST_OUT = 1'b1;

        // Engine: len=5, div=1, TMS all ones.
        host_sel = 1'b0;
        repeat (2) tick();
        chk("own_engine", own_host, 0);
        zero_stats();
        run_shift(5, 1, 32'h0000_001F, 32'h0, t);
        chk("len5_done_time", t, 20);
        chk("len5_rises", rises, 5);
        chk("len5_high_cycles", high_cyc, 10);
        chk("len5_tms_after", TMS, 1);
        chk("len5_tdo", tdo_vec, 32'h0);
        chk("len5_dones", dones, 1);

        // Loopback capture: len=8, div=2.
        zero_stats();
        run_shift(8, 2, 32'h0, 32'h0000_00A5, t);
        chk("len8_done_time", t, 48);
        chk("len8_tdo", tdo_vec, 32'h0000_00A5);
        chk("len8_dones", dones, 1);

        // trst_req and start together: reset pulse wins, start is lost.
        zero_stats();
        len = 6'd4; tck_div = 8'd0; tdi_vec = 32'hF;
        trst_req = 1'b1; start = 1'b1;
        tick();
        trst_req = 1'b0; start = 1'b0;
        t = 0;
        while (!done && t < 100) begin tick(); t++; end
        chk("trst_done_seen", done, 1);
        repeat (3) tick();
        chk("trst_low_cycles", ntrst_low, 16);
        chk("trst_no_tck", rises, 0);
        chk("trst_dones", dones, 1);
        chk("trst_tdo_kept", tdo_vec, 32'h0000_00A5);

        // 32-bit shift with a mid-shift ownership request.
        zero_stats();
        len = 6'd32; tck_div = 8'd0; tms_vec = 32'h8000_0001; tdi_vec = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        host_sel = 1'b1;
        t = 0;
        while (!done && t < 200) begin tick(); t++; end
        chk("len32_done_seen", done, 1);
        chk("len32_own_at_done", own_host, 0);
        chk("len32_rises", rises, 32);
        chk("len32_tdo", tdo_vec, 32'hDEAD_BEEF);
        tick();
        chk("len32_own_idle", own_host, 0);
        tick();
        chk("len32_own_flip", own_host, 1);
        FT_TCK = 1'b1; FT_TDI = 1'b1;
        #1;
        chk("len32_pass_TCK", TCK, 1);
        chk("len32_pass_TDI", TDI, 1);
        tick();
        FT_TCK = 1'b0; FT_TDI = 1'b0;
        tick();

        // Async reset during the 3rd bit of a len=10 shift.
        host_sel = 1'b0;
        repeat (3) tick();
        len = 6'd10; tck_div = 8'd1; tms_vec = 32'h0; tdi_vec = 32'h3FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("mid_busy", busy, 1);
        chk("mid_partial_tdo", tdo_vec, 32'h3);
        #1;
        nRST = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_tdo", tdo_vec, 0);
        chk("arst_TCK", TCK, 0);
        chk("arst_TMS", TMS, 1);
        chk("arst_own", own_host, 1);
        repeat (2) tick();
        nRST = 1'b1;
        repeat (3) tick();
        zero_stats();
        len = 6'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        len = 6'd33; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("badlen_dones", dones, 0);
        chk("badlen_busy", busy, 0);
        chk("badlen_TMS", TMS, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jtag_shift_engine.md
Name: jtag_shift_engine

Overview:
- Sequencer and owner-arbiter for the target JTAG port (TCK/TMS/TDI/TDO/nTRST) on the Bus Blaster buffer CPLD.
- Either passes the FT2232 JTAG pins straight through (host owner), or runs an internal engine that shifts up to DATA_W bits of TMS/TDI with a divided TCK and captures TDO.
- The engine can also issue a timed nTRST pulse.

Parameters:
- DATA_W, 32, maximum bits per shift and width of the vectors.
- LEN_W, 6, width of the len port; must hold DATA_W.
- DIV_W, 8, width of the TCK half-period divider.
- TRST_CYC, 16, CLK cycles nTRST is held low per reset request.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- host_sel  in  1  1 = FT pins own the target port, 0 = engine owns it.
- FT_TCK  in  1  host TCK.
- FT_TMS  in  1  host TMS.
- FT_TDI  in  1  host TDI.
- FT_nTRST_OUT  in  1  host nTRST.
- FT_TDO  out  1  TDO returned to host.
- start  in  1  one-cycle request to shift.
- trst_req  in  1  one-cycle request for an nTRST pulse.
- len  in  LEN_W  number of bits to shift, 1..DATA_W.
- tck_div  in  DIV_W  half-period = tck_div+1 CLK cycles.
- tms_vec  in  DATA_W  TMS bits, LSB first.
- tdi_vec  in  DATA_W  TDI bits, LSB first.
- tdo_vec  out  DATA_W  captured TDO bits, LSB first.
- busy  out  1  engine active (SHIFT or RST).
- done  out  1  one-cycle completion pulse.
- own_host  out  1  current owner flag.
- TDO  in  1  target TDO.
- TCK  out  1  target TCK.
- TMS  out  1  target TMS.
- TDI  out  1  target TDI.
- nTRST  out  1  target nTRST.

Behaviour:
- Reset (nRST low, asynchronous), engine registers:
  - TCK=0, TMS=1, TDI=0, nTRST=1.
  - busy=0, done=0, tdo_vec=0, state IDLE.
  - own_host=1, so host pass-through is active out of reset.
- FT_TDO = TDO combinationally, always.
- Ownership:
  - own_host is registered from host_sel only in state IDLE; a change while busy is deferred until the engine returns to IDLE.
  - own_host=1: TCK/TMS/TDI/nTRST = FT_TCK/FT_TMS/FT_TDI/FT_nTRST_OUT combinationally.
  - own_host=1: start and trst_req are ignored.
  - own_host=0: target pins come from the engine registers.
- States: IDLE, LOW, HIGH, RST, DONE.
- IDLE:
  - trst_req=1: latch counter, set nTRST=0, go to RST. trst_req has priority over start in the same cycle.
  - start=1 with len in 1..DATA_W:
    - latch len, tck_div, tms_vec and tdi_vec.
    - clear tdo_vec; set bit index to 0 and divider to 0.
    - drive TMS=tms[0], TDI=tdi[0], TCK=0; go to LOW.
  - start with len=0 or len>DATA_W is ignored: no busy, no done.
- busy=1 in LOW, HIGH and RST (registered, so it asserts the cycle after start).
- LOW:
  - Divider counts 0..div.
  - At div: TCK<=1, tdo_vec[idx]<=TDO (sampled that edge), divider cleared, go to HIGH.
- HIGH:
  - At div: TCK<=0.
  - If idx==len-1, go to DONE.
  - Otherwise idx++, TMS/TDI <= next bit, go to LOW. TMS/TDI change only together with the TCK falling edge.
- Per-bit cost: exactly 2*(div+1) CLK cycles.
- Shift duration: first rising TCK is (div+1) cycles after the LOW entry; DONE is entered len*2*(div+1) cycles after the LOW entry.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - TMS/TDI hold the last shifted bit, so the TAP state stays stable.
  - tdo_vec holds until the next accepted start.
- RST:
  - nTRST held low for TRST_CYC cycles, then nTRST=1, then DONE (done pulses).
  - TCK stays 0 and TMS stays at its current value.
- start or trst_req while busy or in DONE: ignored, not queued.
- Mid-operation nRST: everything returns to reset values immediately; a partial tdo_vec is discarded (cleared).

Test Plan:
- Reset release with host_sel=1: toggling FT_TCK/FT_TMS/FT_TDI/FT_nTRST_OUT -> TCK/TMS/TDI/nTRST mirror them in the same cycle; FT_TDO follows TDO; busy=0.
- host_sel=0, tck_div=1, len=5, tms_vec=0x1F, tdi_vec=0x00 -> 5 TCK pulses of 2 high + 2 low cycles; TMS=1 throughout; done 20 cycles after LOW entry; TMS stays 1 afterwards.
- len=8, tdi_vec=0xA5, TDO looped back from TDI through a falling-edge flop model -> tdo_vec=0xA5, done one cycle, busy low the same cycle.
- trst_req and start in the same cycle (TRST_CYC=16) -> nTRST low for exactly 16 cycles, no TCK edges, done pulse; the start is lost.
- host_sel set to 1 during a 32-bit shift -> the shift completes all 32 bits; own_host flips only after DONE→IDLE; pins then pass through.
- nRST asserted during the 3rd bit of len=10 -> TCK=0, TMS=1, busy=0, tdo_vec=0 immediately; a subsequent start with len=0 -> no busy, no done.
